// File: rtl/alu_pkg.sv
// Shared opcodes, header size and FSM state encoding for the UART ALU responder.
package alu_pkg;

    localparam logic [7:0] OP_ECHO   = 8'hEC;
    localparam logic [7:0] OP_ADD    = 8'hAD;
    localparam logic [7:0] OP_MUL    = 8'h88;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [3:0] {
        HDR_OP,
        HDR_RSV,
        HDR_LEN_LO,
        HDR_LEN_HI,
        ECHO,
        COLLECT,
        MUL,
        RESP,
        DRAIN
    } state_t;

endpackage

// File: rtl/alu_mul32_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, W cycles per
// operation, product truncated to W bits. done_o marks the final step; product_o
// already includes that step's partial product when done_o is high.
module alu_mul32_seq #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         done_o,
    output logic [W-1:0] product_o
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  a_q, b_q, p_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [W-1:0]  p_d;

    // Partial product of the current step.
    always_comb begin
        p_d = b_q[0] ? p_q + a_q : p_q;
    end

    assign done_o    = run_q && (cnt_q == CW'(W - 1));
    assign product_o = p_d;

    // Load operands on start, then shift multiplicand left / multiplier right.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            p_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            p_q   <= p_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_responder.sv
// Command engine for the UART ALU: parses framed packets, runs echo/add/mul and
// streams the reply bytes out.
//
// state      | meaning
// HDR_OP     | idle, waiting for opcode byte
// HDR_RSV    | reserved header byte, ignored
// HDR_LEN_LO | packet length low byte
// HDR_LEN_HI | packet length high byte, payload count loaded
// ECHO       | payload forwarded through a one-entry output register
// COLLECT    | payload assembled into little-endian operands
// MUL        | multiplier running, input backpressured
// RESP       | accumulator sent LSB first
// DRAIN      | unknown opcode, payload swallowed
module alu_cmd_responder
    import alu_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy
);
    localparam int NB = DATA_W / 8;
    localparam int BW = $clog2(NB);

    state_t              state_q;
    logic                rdy_en_q;
    logic [7:0]          opcode_q, len_lo_q;
    logic [LEN_W-1:0]    rem_q;
    logic [BW-1:0]       bcnt_q, ocnt_q;
    logic [DATA_W-9:0]   opw_q;
    logic [DATA_W-1:0]   acc_q, res_q;
    logic                any_q;
    logic [7:0]          m_tdata_q;
    logic                m_tvalid_q;

    logic                ready_d, s_fire, m_fire;
    logic [LEN_W-1:0]    len_d, pay_d;
    logic [DATA_W-1:0]   op_full, sum_d, mul_prod;
    logic                mul_start, mul_done;

    // Input acceptance depends only on state and the output stage, never on s_axis_tvalid.
    always_comb begin
        ready_d = 1'b0;
        case (state_q)
            HDR_OP, HDR_RSV, HDR_LEN_LO, HDR_LEN_HI, COLLECT, DRAIN: ready_d = 1'b1;
            ECHO:    ready_d = (rem_q != '0) && (!m_tvalid_q || m_axis_tready);
            default: ready_d = 1'b0;
        endcase
    end

    assign s_axis_tready = rdy_en_q && ready_d;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_tvalid_q && m_axis_tready;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign busy          = (state_q != HDR_OP);

    assign len_d     = {s_axis_tdata, len_lo_q};
    assign pay_d     = (len_d < LEN_W'(HDR_BYTES)) ? '0 : len_d - LEN_W'(HDR_BYTES);
    assign op_full   = {s_axis_tdata, opw_q};
    assign sum_d     = acc_q + op_full;
    assign mul_start = (state_q == COLLECT) && s_fire && (bcnt_q == BW'(NB - 1))
                       && (opcode_q == OP_MUL);

    alu_mul32_seq #(.W(DATA_W)) u_mul (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (mul_start),
        .a_i       (acc_q),
        .b_i       (op_full),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Packet FSM with registered response stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HDR_OP;
            rdy_en_q   <= 1'b0;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            bcnt_q     <= '0;
            ocnt_q     <= '0;
            opw_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            any_q      <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                HDR_OP: if (s_fire) begin
                    opcode_q <= s_axis_tdata;
                    state_q  <= HDR_RSV;
                end
                HDR_RSV: if (s_fire) state_q <= HDR_LEN_LO;
                HDR_LEN_LO: if (s_fire) begin
                    len_lo_q <= s_axis_tdata;
                    state_q  <= HDR_LEN_HI;
                end
                HDR_LEN_HI: if (s_fire) begin
                    rem_q  <= pay_d;
                    bcnt_q <= '0;
                    any_q  <= 1'b0;
                    acc_q  <= (opcode_q == OP_MUL) ? DATA_W'(1) : '0;
                    if (pay_d != '0) begin
                        case (opcode_q)
                            OP_ECHO:        state_q <= ECHO;
                            OP_ADD, OP_MUL: state_q <= COLLECT;
                            default:        state_q <= DRAIN;
                        endcase
                    end else if (opcode_q == OP_ADD || opcode_q == OP_MUL) begin
                        res_q      <= '0;
                        m_tdata_q  <= '0;
                        m_tvalid_q <= 1'b1;
                        ocnt_q     <= '0;
                        state_q    <= RESP;
                    end else begin
                        state_q <= HDR_OP;
                    end
                end
                ECHO: begin
                    if (m_fire) m_tvalid_q <= 1'b0;
                    if (s_fire) begin
                        m_tdata_q  <= s_axis_tdata;
                        m_tvalid_q <= 1'b1;
                        rem_q      <= rem_q - LEN_W'(1);
                    end
                    if (rem_q == '0 && (!m_tvalid_q || m_fire)) state_q <= HDR_OP;
                end
                COLLECT: if (s_fire) begin
                    rem_q  <= rem_q - LEN_W'(1);
                    opw_q  <= {s_axis_tdata, opw_q[DATA_W-9:8]};
                    bcnt_q <= bcnt_q + BW'(1);
                    if (bcnt_q == BW'(NB - 1)) begin
                        if (opcode_q == OP_MUL) begin
                            state_q <= MUL;
                        end else begin
                            acc_q <= sum_d;
                            any_q <= 1'b1;
                            if (rem_q == LEN_W'(1)) begin
                                res_q      <= sum_d;
                                m_tdata_q  <= sum_d[7:0];
                                m_tvalid_q <= 1'b1;
                                ocnt_q     <= '0;
                                state_q    <= RESP;
                            end
                        end
                    end else if (rem_q == LEN_W'(1)) begin
                        // Trailing partial operand: reply with whatever completed.
                        res_q      <= any_q ? acc_q : '0;
                        m_tdata_q  <= any_q ? acc_q[7:0] : 8'h00;
                        m_tvalid_q <= 1'b1;
                        ocnt_q     <= '0;
                        state_q    <= RESP;
                    end
                end
                MUL: if (mul_done) begin
                    acc_q <= mul_prod;
                    any_q <= 1'b1;
                    if (rem_q == '0) begin
                        res_q      <= mul_prod;
                        m_tdata_q  <= mul_prod[7:0];
                        m_tvalid_q <= 1'b1;
                        ocnt_q     <= '0;
                        state_q    <= RESP;
                    end else begin
                        state_q <= COLLECT;
                    end
                end
                RESP: if (m_axis_tready) begin
                    if (ocnt_q == BW'(NB - 1)) begin
                        m_tvalid_q <= 1'b0;
                        state_q    <= HDR_OP;
                    end else begin
                        ocnt_q    <= ocnt_q + BW'(1);
                        res_q     <= res_q >> 8;
                        m_tdata_q <= res_q[15:8];
                    end
                end
                DRAIN: if (s_fire) begin
                    rem_q <= rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_q <= HDR_OP;
                end
                default: state_q <= HDR_OP;
            endcase
        end
    end

endmodule
